instruction_fetch_unit: RTL and testbench

//  Fetch stage of the KGP-RISC core. Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.

---
 rtl/kgp_risc_pkg.sv | 11 +
 rtl/program_counter_reg.sv | 22 ++
 rtl/instruction_fetch_unit.sv | 76 +++++++
 tb/tb_instruction_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: shared widths, fetch FSM states and address helpers for the KGP-RISC core.
package kgp_risc_pkg;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int IMM21_W = 21;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = '0;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, SQUASH} fetch_state_t;
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~(ADDR_W'(3));
  endfunction
endpackage

// File: rtl/program_counter_reg.sv
// program_counter_reg: fetch PC register; a redirect load takes precedence over the post-fetch increment.
module program_counter_reg
  import kgp_risc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);
  logic [ADDR_W-1:0] r_pc;
  assign o_pc = r_pc;
  // Wraps modulo 2^32 with no overflow flag.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pc <= RESET_PC;
    else if (i_load) r_pc <= word_align(i_target);
    else if (i_inc) r_pc <= r_pc + ADDR_W'(PC_STEP);
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: KGP-RISC fetch stage; one outstanding imem request, valid/ready to decode,
// redirects squash wrong-path fetches without ever changing an in-flight address.
module instruction_fetch_unit
  import kgp_risc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [IMM21_W-1:0] imm21,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target
);
  fetch_state_t      r_state;
  logic [ADDR_W-1:0] w_pc;
  logic              w_ack;
  assign w_ack = imem_req & imem_ack;
  assign imm21 = instr[IMM21_W-1:0];
  program_counter_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .clk      (clk),
    .rst_n    (rst),
    .i_load   (redirect_valid),
    .i_target (redirect_target),
    .i_inc    ((r_state == FETCH) & w_ack),
    .o_pc     (w_pc)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (!redirect_valid) begin
            r_state   <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= w_pc;
          end
        // A redirect with no ack must let the current request finish before reissuing.
        FETCH:
          if (w_ack) begin
            imem_req <= 1'b0;
            r_state  <= redirect_valid ? IDLE : HOLD;
            if (!redirect_valid) begin
              instr       <= imem_rdata;
              instr_pc    <= imem_addr;
              instr_valid <= 1'b1;
            end
          end else if (redirect_valid) r_state <= SQUASH;
        HOLD:
          if (redirect_valid || instr_ready) begin
            instr_valid <= 1'b0;
            r_state     <= IDLE;
          end
        SQUASH:
          if (w_ack) begin
            imem_req <= 1'b0;
            r_state  <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenario tasks plus a randomized run scored against a
// transaction-level model (next delivered PC = last redirect target, else previous PC + 4).
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic [20:0] imm21;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  int n_cmp = 0, n_bad = 0;
  int lat = 1, cur_lat = 1, cnt = 0;
  bit rand_lat = 0, spur = 0;
  logic [31:0] sp_addr = 32'hFFFF_FFFF, sp_word = '0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .imm21(imm21), .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == sp_addr) return sp_word;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction memory: ack after cur_lat wait cycles; optional stray acks while idle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin imem_ack = 1'b0; cnt = 0; end
    else if (imem_req && !imem_ack) begin
      if (cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
      cnt++;
      if (cnt > cur_lat) begin imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); cnt = 0; end
    end else begin
      if (!imem_req) cnt = 0;
      imem_ack = spur && !imem_req && ($urandom_range(0, 5) == 0);
      imem_rdata = $urandom;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin ok = 1; return; end
    end
  endtask

  task automatic test_reset();
    lat = 1;
    do_reset();
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h expected 0", instr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
    n_cmp++; if (imm21 !== 21'h0) begin n_bad++; $display("FAIL reset_imm21: got %h expected 0", imm21); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] addrs[3], vpc[3], vins[3];
    int vcyc[3];
    int na = 0, nv = 0;
    logic prev_req = 1'b0;
    lat = 1;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (imem_req && !prev_req && na < 3) begin addrs[na] = imem_addr; na++; end
      if (instr_valid && nv < 3) begin vcyc[nv] = i; vpc[nv] = instr_pc; vins[nv] = instr; nv++; end
      prev_req = imem_req;
    end
    n_cmp++;
    if (na != 3 || nv != 3) begin
      n_bad++; $display("FAIL seq_counts: got %0d reqs %0d valids expected 3 and 3", na, nv);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (addrs[k] !== 32'(4 * k)) begin n_bad++; $display("FAIL seq_addr%0d: got %h expected %h", k, addrs[k], 32'(4 * k)); end
        n_cmp++;
        if ({vpc[k], vins[k]} !== {32'(4 * k), mem_word(32'(4 * k))}) begin
          n_bad++; $display("FAIL seq_instr%0d: got pc=%h instr=%h expected pc=%h instr=%h", k, vpc[k], vins[k], 32'(4 * k), mem_word(32'(4 * k)));
        end
      end
      for (int k = 1; k < 3; k++) begin
        n_cmp++;
        if (vcyc[k] - vcyc[k-1] != 4) begin n_bad++; $display("FAIL seq_spacing%0d: got %0d cycles expected 4", k, vcyc[k] - vcyc[k-1]); end
      end
    end
  endtask

  task automatic test_imm();
    bit ok;
    logic [31:0] sx;
    sp_addr = 32'h0; sp_word = 32'h1C1F_FFFF; lat = 1;
    do_reset();
    instr_ready = 1'b1;
    wait_accept(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL imm_timeout: got no accept expected one"); end
    else begin
      n_cmp++; if (imm21 !== 21'h1F_FFFF) begin n_bad++; $display("FAIL imm21: got %h expected 1fffff", imm21); end
      sx = {{11{imm21[20]}}, imm21};
      n_cmp++; if (sx !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL imm_sext: got %h expected ffffffff", sx); end
    end
    sp_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_stall();
    logic [31:0] i0, p0;
    bit seen = 0;
    lat = 1;
    do_reset();
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = instr_valid; end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL stall_timeout: got no valid expected valid"); return; end
    i0 = instr; p0 = instr_pc;
    n_cmp++;
    if ({p0, i0} !== {32'h0, mem_word(32'h0)}) begin n_bad++; $display("FAIL stall_first: got pc=%h instr=%h expected pc=0 instr=%h", p0, i0, mem_word(32'h0)); end
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if ({instr_valid, imem_req, instr, instr_pc} !== {1'b1, 1'b0, i0, p0}) begin
        n_bad++; $display("FAIL stall_hold: got v=%b req=%b instr=%h pc=%h expected v=1 req=0 instr=%h pc=%h", instr_valid, imem_req, instr, instr_pc, i0, p0);
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({instr_valid, imem_req} !== 2'b00) begin n_bad++; $display("FAIL stall_after_accept: got v=%b req=%b expected 0 0", instr_valid, imem_req); end
    @(negedge clk);
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin n_bad++; $display("FAIL stall_next_req: got req=%b addr=%h expected req=1 addr=4", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_squash();
    bit seen = 0, gap = 0, vseen = 0, newreq = 0;
    bit ok;
    lat = 3;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin @(negedge clk); seen = imem_req && imem_addr == 32'h8; end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL squash_timeout: got no fetch of 8 expected one"); return; end
    redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !newreq; i++) begin
      if (instr_valid) vseen = 1;
      if (!imem_req) gap = 1;
      else if (gap) newreq = 1;
      else begin
        n_cmp++;
        if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL squash_addr_stable: got %h expected 8", imem_addr); end
      end
      if (!newreq) @(negedge clk);
    end
    n_cmp++; if (vseen) begin n_bad++; $display("FAIL squash_valid: got valid=1 expected 0"); end
    n_cmp++;
    if (!newreq || imem_addr !== 32'h100) begin n_bad++; $display("FAIL squash_next_addr: got req=%b addr=%h expected req=1 addr=100", newreq, imem_addr); end
    wait_accept(ok);
    n_cmp++;
    if (!ok || {instr_pc, instr} !== {32'h100, mem_word(32'h100)}) begin
      n_bad++; $display("FAIL squash_deliver: got ok=%b pc=%h instr=%h expected pc=100 instr=%h", ok, instr_pc, instr, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_ack();
    bit seen = 0, vseen = 0, rose = 0;
    bit ok;
    lat = 1;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); #1; seen = imem_ack; end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rack_timeout: got no ack expected one"); return; end
    redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !rose; i++) begin
      if (instr_valid) vseen = 1;
      rose = imem_req;
      if (!rose) @(negedge clk);
    end
    n_cmp++; if (vseen) begin n_bad++; $display("FAIL rack_valid: got valid=1 expected 0"); end
    n_cmp++;
    if (!rose || imem_addr !== 32'h200) begin n_bad++; $display("FAIL rack_next_addr: got req=%b addr=%h expected req=1 addr=200", rose, imem_addr); end
    wait_accept(ok);
    n_cmp++;
    if (!ok || instr_pc !== 32'h200) begin n_bad++; $display("FAIL rack_deliver: got ok=%b pc=%h expected pc=200", ok, instr_pc); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_pc[2];
    exp_pc[0] = 32'hFFFF_FFFC; exp_pc[1] = 32'h0;
    lat = 1;
    do_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_accept(ok);
      n_cmp++;
      if (!ok || {instr_pc, instr} !== {exp_pc[k], mem_word(exp_pc[k])}) begin
        n_bad++; $display("FAIL wrap%0d: got ok=%b pc=%h instr=%h expected pc=%h instr=%h", k, ok, instr_pc, instr, exp_pc[k], mem_word(exp_pc[k]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h0, h_instr = '0, h_pc = '0, h_addr = '0, w;
    bit h_valid = 0, h_req = 0;
    int n_acc = 0;
    rand_lat = 1; spur = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (h_valid) begin
        n_cmp++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, h_instr, h_pc}) begin
          n_bad++; $display("FAIL rnd_hold: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=%h", instr_valid, instr, instr_pc, h_instr, h_pc);
        end
      end
      if (h_req) begin
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, h_addr}) begin
          n_bad++; $display("FAIL rnd_req_stable: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, h_addr);
        end
      end
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_target = $urandom;
      if (redirect_valid) exp_pc = redirect_target & 32'hFFFF_FFFC;
      else if (instr_valid && instr_ready) begin
        w = mem_word(exp_pc);
        n_cmp++;
        if ({instr_pc, instr, imm21} !== {exp_pc, w, w[20:0]}) begin
          n_bad++; $display("FAIL rnd_deliver: got pc=%h instr=%h imm=%h expected pc=%h instr=%h imm=%h", instr_pc, instr, imm21, exp_pc, w, w[20:0]);
        end
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      h_valid = instr_valid && !instr_ready && !redirect_valid;
      h_instr = instr; h_pc = instr_pc;
      h_req = imem_req && !imem_ack; h_addr = imem_addr;
    end
    n_cmp++;
    if (n_acc < 100) begin n_bad++; $display("FAIL rnd_progress: got %0d accepts expected at least 100", n_acc); end
    rand_lat = 0; spur = 0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_imm();
    test_stall();
    test_redirect_squash();
    test_redirect_ack();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
